// File: rtl/down_count_monitor_if.sv
// Bundle of count-sample inputs and monitor status outputs for down_count_monitor.
// master: drives the count samples and observes status (bench or upstream wrapper).
// slave:  the monitor itself, consuming samples and producing status.
interface down_count_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] count_in;
  logic             count_valid;
  logic             ctr_clear;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] wrap_cnt;
  logic [WIDTH-1:0] expected;

  modport master (
    output count_in, count_valid, ctr_clear,
    input  locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt, expected
  );

  modport slave (
    input  count_in, count_valid, ctr_clear,
    output locked, err_pulse, wrap_pulse, err_cnt, wrap_cnt, expected
  );
endinterface

// File: rtl/down_count_monitor.sv
// Checks that a sampled down-counter steps by exactly -1 (mod 2^WIDTH); counts wraps and errors.
// Latency: every status output is registered and updates on the edge that takes the sample.
// Backpressure: none; count_valid qualifies a sample, gaps of any length simply hold state.
// Ports: clk, clear_n (sync active-low reset), mon (slave modport: count_in/count_valid/ctr_clear in;
//        locked/err_pulse/wrap_pulse/err_cnt/wrap_cnt/expected out).
module down_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int CNT_W      = 8,
  parameter int MISS_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  clear_n,
  down_count_monitor_if.slave   mon
);

  localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_pulse_q, wrap_pulse_d;

  logic             sample_match;
  logic [3:0]       miss_inc;
  logic             miss_hit;
  logic [WIDTH-1:0] count_dec;

  assign sample_match = (mon.count_in == expected_q);
  assign miss_inc     = miss_cnt_q + 4'd1;
  assign miss_hit     = (miss_inc == MISS_LIM);
  assign count_dec    = mon.count_in - WIDTH'(1);

  // State register (and all other flops)
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q      <= UNLOCKED;
      expected_q   <= '0;
      miss_cnt_q   <= '0;
      err_cnt_q    <= '0;
      wrap_cnt_q   <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      miss_cnt_q   <= miss_cnt_d;
      err_cnt_q    <= err_cnt_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (mon.ctr_clear) begin
      state_d = UNLOCKED;
    end else if (mon.count_valid) begin
      if (state_q == UNLOCKED) begin
        state_d = LOCKED;
      end else if (!sample_match && miss_hit) begin
        state_d = UNLOCKED;
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    expected_d   = expected_q;
    miss_cnt_d   = miss_cnt_q;
    err_cnt_d    = err_cnt_q;
    wrap_cnt_d   = wrap_cnt_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    if (mon.ctr_clear) begin
      expected_d = '0;
      miss_cnt_d = '0;
    end else if (mon.count_valid) begin
      // Always re-anchor on the observed value so one glitch costs one error, not many.
      expected_d = count_dec;
      if (state_q == UNLOCKED) begin
        miss_cnt_d = '0;
      end else if (sample_match) begin
        miss_cnt_d = '0;
        if (mon.count_in == '1) begin
          wrap_pulse_d = 1'b1;
          if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
        end
      end else begin
        err_pulse_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        miss_cnt_d = miss_hit ? 4'd0 : miss_inc;
      end
    end
  end

  assign mon.locked     = (state_q == LOCKED);
  assign mon.err_pulse  = err_pulse_q;
  assign mon.wrap_pulse = wrap_pulse_q;
  assign mon.err_cnt    = err_cnt_q;
  assign mon.wrap_cnt   = wrap_cnt_q;
  assign mon.expected   = expected_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed self-checking bench for down_count_monitor (WIDTH=4, CNT_W=8, MISS_LIMIT=3).
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next rising edge.
// Every expected value is written out by hand in the vector calls below.
module tb_down_count_monitor;

  logic clk;
  logic clear_n;
  int   n_chk;
  int   n_bad;

  down_count_monitor_if #(.WIDTH(4), .CNT_W(8)) mon_if ();

  down_count_monitor #(.WIDTH(4), .CNT_W(8), .MISS_LIMIT(3)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .mon     (mon_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic n, input logic v, input logic cc, input logic [3:0] cin);
    clear_n            = n;
    mon_if.count_valid = v;
    mon_if.ctr_clear   = cc;
    mon_if.count_in    = cin;
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then check locked / err_pulse / wrap_pulse / expected.
  task automatic vec(input string tag, input logic n, input logic v, input logic cc,
                     input logic [3:0] cin, input logic lk, input logic ep,
                     input logic wp, input logic [3:0] ex);
    step(n, v, cc, cin);
    check_val({tag, ".locked"},     32'(mon_if.locked),     32'(lk));
    check_val({tag, ".err_pulse"},  32'(mon_if.err_pulse),  32'(ep));
    check_val({tag, ".wrap_pulse"}, 32'(mon_if.wrap_pulse), 32'(wp));
    check_val({tag, ".expected"},   32'(mon_if.expected),   32'(ex));
  endtask

  task automatic cnts(input string tag, input logic [7:0] ec, input logic [7:0] wc);
    check_val({tag, ".err_cnt"},  32'(mon_if.err_cnt),  32'(ec));
    check_val({tag, ".wrap_cnt"}, 32'(mon_if.wrap_cnt), 32'(wc));
  endtask

  initial begin
    logic [3:0] fr;
    n_chk = 0;
    n_bad = 0;
    clear_n            = 1'b0;
    mon_if.count_valid = 1'b0;
    mon_if.ctr_clear   = 1'b0;
    mon_if.count_in    = 4'h0;
    #2;

    // Reset wins over a valid sample
    vec("rst0", 0, 1, 0, 4'h5, 0, 0, 0, 4'h0);
    cnts("rst0", 8'h00, 8'h00);

    // Clean descending run through the 0 -> F wrap
    vec("s5", 1, 1, 0, 4'h5, 1, 0, 0, 4'h4);
    vec("s4", 1, 1, 0, 4'h4, 1, 0, 0, 4'h3);
    vec("s3", 1, 1, 0, 4'h3, 1, 0, 0, 4'h2);
    vec("s2", 1, 1, 0, 4'h2, 1, 0, 0, 4'h1);
    vec("s1", 1, 1, 0, 4'h1, 1, 0, 0, 4'h0);
    vec("s0", 1, 1, 0, 4'h0, 1, 0, 0, 4'hF);
    vec("sF", 1, 1, 0, 4'hF, 1, 0, 1, 4'hE);
    vec("sE", 1, 1, 0, 4'hE, 1, 0, 0, 4'hD);
    cnts("run1", 8'h00, 8'h01);

    // Single skipped value: one error, resync, stays locked
    vec("clr1", 1, 0, 1, 4'h3, 0, 0, 0, 4'h0);
    vec("r9",   1, 1, 0, 4'h9, 1, 0, 0, 4'h8);
    vec("m8",   1, 1, 0, 4'h8, 1, 0, 0, 4'h7);
    vec("e6",   1, 1, 0, 4'h6, 1, 1, 0, 4'h5);
    cnts("e6", 8'h01, 8'h01);
    vec("m5",   1, 1, 0, 4'h5, 1, 0, 0, 4'h4);
    cnts("m5", 8'h01, 8'h01);

    // Three consecutive mismatches drop lock; next sample relocks silently
    vec("x3", 1, 1, 0, 4'h3, 1, 1, 0, 4'h2);
    vec("x7", 1, 1, 0, 4'h7, 1, 1, 0, 4'h6);
    vec("xB", 1, 1, 0, 4'hB, 0, 1, 0, 4'hA);
    cnts("xB", 8'h04, 8'h01);
    vec("r2", 1, 1, 0, 4'h2, 1, 0, 0, 4'h1);
    cnts("r2", 8'h04, 8'h01);

    // Idle gap: count_in would match, but it is not qualified
    for (int i = 0; i < 3; i++) vec("gap", 1, 0, 0, 4'h1, 1, 0, 0, 4'h1);

    // ctr_clear outranks a simultaneous valid sample
    vec("ccA", 1, 1, 1, 4'hA, 0, 0, 0, 4'h0);
    vec("rF",  1, 1, 0, 4'hF, 1, 0, 0, 4'hE);
    cnts("rF", 8'h04, 8'h01);

    // Second wrap, then reset mid-run clears everything
    vec("clr2", 1, 0, 1, 4'h0, 0, 0, 0, 4'h0);
    vec("r0",   1, 1, 0, 4'h0, 1, 0, 0, 4'hF);
    vec("wF",   1, 1, 0, 4'hF, 1, 0, 1, 4'hE);
    cnts("wF", 8'h04, 8'h02);
    vec("rst1", 0, 1, 1, 4'hE, 0, 0, 0, 4'h0);
    cnts("rst1", 8'h00, 8'h00);
    vec("rl7",  1, 1, 0, 4'h7, 1, 0, 0, 4'h6);

    // Free-running counter from 0: 263 locked wraps, so wrap_cnt must pin at FF
    vec("clr3", 1, 0, 1, 4'h0, 0, 0, 0, 4'h0);
    fr = 4'h0;
    for (int i = 0; i < 4200; i++) begin
      step(1, 1, 0, fr);
      fr = fr - 4'h1;
    end
    check_val("fr.locked", 32'(mon_if.locked), 32'h1);
    cnts("fr", 8'h00, 8'hFF);
    // One more wrap while saturated: pulse fires, count holds
    vec("clr4", 1, 0, 1, 4'h0, 0, 0, 0, 4'h0);
    vec("r0b",  1, 1, 0, 4'h0, 1, 0, 0, 4'hF);
    vec("wFs",  1, 1, 0, 4'hF, 1, 0, 1, 4'hE);
    cnts("wFs", 8'h00, 8'hFF);

    // Constant 5: lock, err, err, err(unlock), lock ... => 3 errors per 4 samples
    vec("clr5", 1, 0, 1, 4'h0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 360; i++) begin
      step(1, 1, 0, 4'h5);
      if (i == 7) check_val("es.err_cnt_8", 32'(mon_if.err_cnt), 32'h6);
    end
    check_val("es.err_pulse", 32'(mon_if.err_pulse), 32'h1);
    check_val("es.locked",    32'(mon_if.locked),    32'h0);
    cnts("es", 8'hFF, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
